rx_key_iv_loader: RTL and testbench

//  Frame parser and sequencer behind the UART receiver.
//  - Consumes the byte stream (dout/load) and recognises framed key (K) and IV (I) messages.
//  - Checks each frame and commits the payload to holding registers.
//  - Hands the committed configuration to the downstream cipher core with a ready/ack handshake.
//  - An inter-byte timeout, counted in baud ticks, aborts stalled frames.

---
 rtl/rx_key_iv_loader.sv | 196 +++++++++++++++++++
 tb/tb_rx_key_iv_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_key_iv_loader.sv
// Frame parser behind the UART receiver: recognises SYNC/TYPE/payload/CHK
// key and IV frames, commits checked payloads and exposes them to the cipher.
module rx_key_iv_loader #(
    parameter int          KEY_BYTES     = 16,
    parameter int          IV_BYTES      = 8,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int          TIMEOUT_TICKS = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_load,
    input  logic                   tick,
    input  logic                   cfg_ack,
    output logic [8*KEY_BYTES-1:0] key,
    output logic [8*IV_BYTES-1:0]  iv,
    output logic                   key_valid,
    output logic                   iv_valid,
    output logic                   cfg_ready,
    output logic                   busy,
    output logic                   frame_err,
    output logic [1:0]             err_code
);

    localparam int MAXB = (KEY_BYTES > IV_BYTES) ? KEY_BYTES : IV_BYTES;
    localparam int SW   = 8 * MAXB;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int TW   = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [7:0] TYPE_K = 8'h4B;
    localparam logic [7:0] TYPE_I = 8'h49;

    localparam logic [1:0] ERR_TYPE = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TYPE,
        S_PAYLOAD,
        S_CHECK
    } state_t;

    state_t                 state_q, state_d;
    logic                   is_key_q, is_key_d;
    logic [7:0]             csum_q, csum_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          stage_q, stage_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   commit_q, commit_d;
    logic                   commit_key_q, commit_key_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [8*IV_BYTES-1:0]  iv_q, iv_d;
    logic                   kv_q, kv_d;
    logic                   ivv_q, ivv_d;
    logic [1:0]             err_q, err_d;
    logic                   ferr_q, ferr_d;

    logic [CW-1:0]          last_idx;
    logic                   timeout_hit;

    assign last_idx = is_key_q ? CW'(KEY_BYTES - 1) : CW'(IV_BYTES - 1);

    // A byte on the expiry cycle wins over the timeout.
    assign timeout_hit = (state_q != S_IDLE) && !rx_load && tick &&
                         (tmo_q == TW'(TIMEOUT_TICKS - 1));

    always_comb begin
        state_d      = state_q;
        is_key_d     = is_key_q;
        csum_d       = csum_q;
        cnt_d        = cnt_q;
        stage_d      = stage_q;
        tmo_d        = tmo_q;
        commit_d     = 1'b0;
        commit_key_d = commit_key_q;
        key_d        = key_q;
        iv_d         = iv_q;
        kv_d         = kv_q;
        ivv_d        = ivv_q;
        err_d        = err_q;
        ferr_d       = 1'b0;

        if (rx_load || state_q == S_IDLE) begin
            tmo_d = '0;
        end else if (tick) begin
            tmo_d = tmo_q + TW'(1);
        end

        if (timeout_hit) begin
            state_d = S_IDLE;
            tmo_d   = '0;
            err_d   = ERR_TMO;
            ferr_d  = 1'b1;
        end else if (rx_load) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_TYPE;
                        stage_d = '0;
                    end
                end
                S_TYPE: begin
                    if (rx_data == TYPE_K || rx_data == TYPE_I) begin
                        is_key_d = (rx_data == TYPE_K);
                        csum_d   = rx_data;
                        cnt_d    = '0;
                        state_d  = S_PAYLOAD;
                    end else begin
                        err_d   = ERR_TYPE;
                        ferr_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    stage_d = {stage_q[SW-9:0], rx_data};
                    csum_d  = csum_q ^ rx_data;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == last_idx) begin
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (rx_data == csum_q) begin
                        commit_d     = 1'b1;
                        commit_key_d = is_key_q;
                    end else begin
                        err_d  = ERR_CSUM;
                        ferr_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            endcase
        end

        if (cfg_ack) begin
            kv_d  = 1'b0;
            ivv_d = 1'b0;
        end

        // Commit lands one edge after the CHK strobe and overrides cfg_ack.
        if (commit_q) begin
            if (commit_key_q) begin
                key_d = stage_q[8*KEY_BYTES-1:0];
                kv_d  = 1'b1;
            end else begin
                iv_d  = stage_q[8*IV_BYTES-1:0];
                ivv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            is_key_q     <= 1'b0;
            csum_q       <= '0;
            cnt_q        <= '0;
            stage_q      <= '0;
            tmo_q        <= '0;
            commit_q     <= 1'b0;
            commit_key_q <= 1'b0;
            key_q        <= '0;
            iv_q         <= '0;
            kv_q         <= 1'b0;
            ivv_q        <= 1'b0;
            err_q        <= '0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_key_q     <= is_key_d;
            csum_q       <= csum_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            tmo_q        <= tmo_d;
            commit_q     <= commit_d;
            commit_key_q <= commit_key_d;
            key_q        <= key_d;
            iv_q         <= iv_d;
            kv_q         <= kv_d;
            ivv_q        <= ivv_d;
            err_q        <= err_d;
            ferr_q       <= ferr_d;
        end
    end

    assign key       = key_q;
    assign iv        = iv_q;
    assign key_valid = kv_q;
    assign iv_valid  = ivv_q;
    assign cfg_ready = kv_q & ivv_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = ferr_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_rx_key_iv_loader.sv
// Self-checking bench for rx_key_iv_loader: vector table, hand-written
// corner sequences and random frames against a frame-level reference model.
module tb_rx_key_iv_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_load;
    logic         tick;
    logic         cfg_ack;
    logic [127:0] key;
    logic [63:0]  iv;
    logic         key_valid;
    logic         iv_valid;
    logic         cfg_ready;
    logic         busy;
    logic         frame_err;
    logic [1:0]   err_code;

    int n_chk = 0;
    int n_fail = 0;
    int ferr_seen = 0;

    rx_key_iv_loader dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_load   (rx_load),
        .tick      (tick),
        .cfg_ack   (cfg_ack),
        .key       (key),
        .iv        (iv),
        .key_valid (key_valid),
        .iv_valid  (iv_valid),
        .cfg_ready (cfg_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       ld;
        logic       ack;
        logic       e_busy;
        logic       e_ferr;
        logic [1:0] e_err;
        logic       e_kv;
        logic       e_ivv;
    } vec_t;

    vec_t vq[$];

    task automatic cyc();
        @(posedge clk);
        #1;
        if (frame_err) ferr_seen++;
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_load = 1'b1;
        cyc();
        rx_load = 1'b0;
    endtask

    task automatic gap(input bit en);
        int n;
        n = en ? int'($urandom_range(0, 2)) : 0;
        repeat (n) begin
            tick = 1'($urandom_range(0, 1));
            cyc();
        end
        tick = 1'b0;
    endtask

    // Sends a whole frame; val holds the payload right-aligned, first byte highest.
    task automatic send_frame(input bit is_k, input logic [127:0] val,
                              input logic [7:0] chk_flip, input bit gaps);
        int         n;
        logic [7:0] t;
        logic [7:0] cs;
        logic [7:0] b;
        n  = is_k ? 16 : 8;
        t  = is_k ? 8'h4B : 8'h49;
        cs = t;
        put(8'hA5); gap(gaps);
        put(t);     gap(gaps);
        for (int i = 0; i < n; i++) begin
            b  = val[8*(n-1-i) +: 8];
            cs = cs ^ b;
            put(b); gap(gaps);
        end
        put(cs ^ chk_flip);
    endtask

    task automatic addv(input logic [7:0] d, input logic ld, input logic ack,
                        input logic bz, input logic fe, input logic [1:0] er,
                        input logic kv, input logic ivv);
        vec_t v;
        v.d = d; v.ld = ld; v.ack = ack; v.e_busy = bz;
        v.e_ferr = fe; v.e_err = er; v.e_kv = kv; v.e_ivv = ivv;
        vq.push_back(v);
    endtask

    logic [127:0] m_key;
    logic [63:0]  m_iv;
    logic         m_kv, m_ivv;
    logic [1:0]   m_err;

    initial begin
        logic [1:0]   er;
        logic         kv, ivv;
        logic [127:0] val;
        logic [7:0]   b;
        int           kind, exp_ferr;
        bit           is_k;

        // Table: tests 1-4 as per-cycle vectors.
        er = 2'b00; kv = 0; ivv = 0;
        addv(8'hA5, 1, 0, 1, 0, er, kv, ivv);
        addv(8'h4B, 1, 0, 1, 0, er, kv, ivv);
        for (int i = 0; i < 16; i++) addv(8'(i), 1, 0, 1, 0, er, kv, ivv);
        addv(8'h4B, 1, 0, 0, 0, er, kv, ivv);
        kv = 1;
        addv(8'h00, 0, 0, 0, 0, er, kv, ivv);
        addv(8'hA5, 1, 0, 1, 0, er, kv, ivv);
        addv(8'h49, 1, 0, 1, 0, er, kv, ivv);
        for (int i = 0; i < 8; i++) addv(8'h11, 1, 0, 1, 0, er, kv, ivv);
        addv(8'h49, 1, 0, 0, 0, er, kv, ivv);
        ivv = 1;
        addv(8'h00, 0, 0, 0, 0, er, kv, ivv);
        kv = 0; ivv = 0;
        addv(8'h00, 0, 1, 0, 0, er, kv, ivv);
        addv(8'hA5, 1, 0, 1, 0, er, kv, ivv);
        addv(8'h4B, 1, 0, 1, 0, er, kv, ivv);
        for (int i = 0; i < 16; i++) addv(8'(i), 1, 0, 1, 0, er, kv, ivv);
        addv(8'h4B, 1, 0, 0, 0, er, kv, ivv);
        kv = 1;
        addv(8'h00, 0, 0, 0, 0, er, kv, ivv);
        addv(8'hA5, 1, 0, 1, 0, er, kv, ivv);
        addv(8'h4B, 1, 0, 1, 0, er, kv, ivv);
        for (int i = 0; i < 16; i++) addv(8'hFF, 1, 0, 1, 0, er, kv, ivv);
        er = 2'b10;
        addv(8'h00, 1, 0, 0, 1, er, kv, ivv);
        addv(8'h00, 0, 0, 0, 0, er, kv, ivv);
        addv(8'h3C, 1, 0, 0, 0, er, kv, ivv);
        addv(8'hA5, 1, 0, 1, 0, er, kv, ivv);
        er = 2'b01;
        addv(8'hA5, 1, 0, 0, 1, er, kv, ivv);
        addv(8'h52, 1, 0, 0, 0, er, kv, ivv);

        reset = 1'b1; rx_load = 1'b0; rx_data = 8'h00;
        tick = 1'b0; cfg_ack = 1'b0;
        cyc(); cyc();
        chk("rst key", key, 128'h0);
        chk("rst iv", iv, 128'h0);
        chk("rst kv", key_valid, 0);
        chk("rst ivv", iv_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst ferr", frame_err, 0);
        chk("rst err", err_code, 0);
        chk("rst ready", cfg_ready, 0);
        reset = 1'b0;

        foreach (vq[i]) begin
            rx_data = vq[i].d; rx_load = vq[i].ld; cfg_ack = vq[i].ack;
            cyc();
            rx_load = 1'b0; cfg_ack = 1'b0;
            chk($sformatf("vec%0d busy", i), busy, vq[i].e_busy);
            chk($sformatf("vec%0d ferr", i), frame_err, vq[i].e_ferr);
            chk($sformatf("vec%0d err", i), err_code, vq[i].e_err);
            chk($sformatf("vec%0d kv", i), key_valid, vq[i].e_kv);
            chk($sformatf("vec%0d ivv", i), iv_valid, vq[i].e_ivv);
            chk($sformatf("vec%0d ready", i), cfg_ready,
                vq[i].e_kv & vq[i].e_ivv);
        end
        chk("tbl key", key, 128'h000102030405060708090A0B0C0D0E0F);
        chk("tbl iv", iv, 128'h1111111111111111);

        // Timeout on the 480th tick.
        put(8'hA5); put(8'h4B); put(8'h00);
        tick = 1'b1;
        repeat (479) cyc();
        chk("tmo pre busy", busy, 1);
        chk("tmo pre ferr", frame_err, 0);
        cyc();
        chk("tmo ferr", frame_err, 1);
        chk("tmo err", err_code, 2'b11);
        chk("tmo busy", busy, 0);
        tick = 1'b0;
        cyc();
        chk("tmo ferr drop", frame_err, 0);
        chk("tmo key kept", key, 128'h000102030405060708090A0B0C0D0E0F);

        // Byte on the expiry tick prevents the timeout and restarts the count.
        put(8'hA5); put(8'h4B); put(8'h00);
        tick = 1'b1;
        repeat (479) cyc();
        ferr_seen = 0;
        rx_data = 8'h01; rx_load = 1'b1;
        cyc();
        rx_load = 1'b0;
        chk("race ferr", frame_err, 0);
        chk("race busy", busy, 1);
        repeat (479) cyc();
        chk("race busy2", busy, 1);
        chk("race no err", ferr_seen, 0);
        cyc();
        chk("race tmo2", frame_err, 1);
        tick = 1'b0;

        // cfg_ack in the commit cycle: the committed flag survives.
        reset = 1'b1; cyc(); reset = 1'b0;
        send_frame(1, 128'hDEADBEEF_01234567_89ABCDEF_55AA33CC, 0, 0);
        cyc();
        chk("c6 kv", key_valid, 1);
        send_frame(0, 128'h0123456789ABCDEF, 0, 0);
        cfg_ack = 1'b1; cyc(); cfg_ack = 1'b0;
        chk("c6 ack ivv", iv_valid, 1);
        chk("c6 ack kv", key_valid, 0);
        chk("c6 ack ready", cfg_ready, 0);
        chk("c6 iv", iv, 128'h0123456789ABCDEF);

        // Strobe in the commit cycle, then reset mid-payload.
        send_frame(1, 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F, 0, 0);
        put(8'hA5);
        chk("c6 strobe kv", key_valid, 1);
        chk("c6 strobe busy", busy, 1);
        chk("c6 strobe key", key, 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F);
        put(8'h4B); put(8'h77); put(8'h66);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("mid rst key", key, 128'h0);
        chk("mid rst iv", iv, 128'h0);
        chk("mid rst kv", key_valid, 0);
        chk("mid rst ivv", iv_valid, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst err", err_code, 0);
        ferr_seen = 0;
        send_frame(1, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 0, 0);
        cyc();
        chk("fresh key", key, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        chk("fresh kv", key_valid, 1);
        chk("fresh ferr", ferr_seen, 0);

        // Random frames against a frame-level model.
        reset = 1'b1; cyc(); reset = 1'b0;
        m_key = '0; m_iv = '0; m_kv = 0; m_ivv = 0; m_err = 0;
        for (int f = 0; f < 150; f++) begin
            ferr_seen = 0;
            exp_ferr  = 0;
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                put(b); gap(1);
            end
            kind = $urandom_range(0, 4);
            is_k = 1'($urandom_range(0, 1));
            val  = {$urandom, $urandom, $urandom, $urandom};
            if (!is_k) val[127:64] = '0;
            if (kind <= 1) begin
                send_frame(is_k, val, 0, 1);
                cyc();
                if (is_k) begin m_key = val; m_kv = 1; end
                else begin m_iv = val[63:0]; m_ivv = 1; end
            end else if (kind == 2) begin
                b = 8'($urandom_range(1, 255));
                send_frame(is_k, val, b, 1);
                m_err = 2'b10; exp_ferr = 1;
            end else if (kind == 3) begin
                b = 8'($urandom);
                if (b == 8'h4B || b == 8'h49) b = 8'h00;
                put(8'hA5); gap(1); put(b);
                m_err = 2'b01; exp_ferr = 1;
            end else begin
                cfg_ack = 1'b1; cyc(); cfg_ack = 1'b0;
                m_kv = 0; m_ivv = 0;
            end
            cyc();
            chk($sformatf("rnd%0d key", f), key, m_key);
            chk($sformatf("rnd%0d iv", f), iv, 128'(m_iv));
            chk($sformatf("rnd%0d kv", f), key_valid, m_kv);
            chk($sformatf("rnd%0d ivv", f), iv_valid, m_ivv);
            chk($sformatf("rnd%0d ready", f), cfg_ready, m_kv & m_ivv);
            chk($sformatf("rnd%0d err", f), err_code, m_err);
            chk($sformatf("rnd%0d busy", f), busy, 0);
            chk($sformatf("rnd%0d ferr", f), ferr_seen, exp_ferr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
